// File: rtl/relu_pkg.sv
// -----------------------------------------------------------------------------
// relu_pkg
// Shared constants and the Q8.8 activation helper for the forward ReLU stage.
//   RELU_NBITS : data width of the autoencoder datapath (signed Q8.8)
//   Q_ONE      : fixed-point 1.0, also the ReLU derivative for non-negative inputs
//   relu_q88() : max(val, 0) on a two's complement Q8.8 value
// -----------------------------------------------------------------------------
package relu_pkg;

    localparam int                    RELU_NBITS = 16;
    localparam logic [RELU_NBITS-1:0] Q_ONE      = 16'd256;

    // Negative values clamp to zero; zero and positive values pass unchanged.
    function automatic logic [RELU_NBITS-1:0] relu_q88(input logic [RELU_NBITS-1:0] val);
        return val[RELU_NBITS-1] ? '0 : val;
    endfunction

endpackage

// File: rtl/relu_skid_buf.sv
// -----------------------------------------------------------------------------
// relu_skid_buf
// Generic valid/ready pipeline stage: one output register plus one skid
// register. Gives one beat per cycle under sustained flow, and in_ready is a
// flop output with no combinational path from out_ready.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : upstream handshake
//   in_data  [WIDTH]    : upstream payload
//   out_valid/out_ready : downstream handshake
//   out_data [WIDTH]    : downstream payload, stable while stalled
// -----------------------------------------------------------------------------
module relu_skid_buf #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;

    logic accept;
    logic out_free;

    // The skid only fills while the output register is stalled, so a full
    // skid is exactly the condition under which we cannot take another beat.
    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & ~skid_valid_q;
    // Output register can take a new beat if empty or being delivered now.
    assign out_free = ~out_valid_q | out_ready;

    always_comb begin
        // NOTE: every signal gets a hold default first so no branch leaves it
        // unassigned, which would otherwise infer a latch.
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (out_free) begin
            if (skid_valid_q) begin
                // Older beat in the skid goes first to preserve order; no
                // accept can happen this cycle because in_ready is low.
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_data_d = in_data;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values
        // regardless of statement order.
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // NOTE: the skid payload is only ever read when skid_valid_q is set, so it
    // carries no reset; this keeps the reset net off a pure data register.
    always_ff @(posedge clk) begin
        skid_data_q <= skid_data_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/relu_fwd_stream.sv
// -----------------------------------------------------------------------------
// relu_fwd_stream
// Forward-pass ReLU stage of the autoencoder datapath. Streams max(val,0) on
// signed Q8.8 beats and publishes a per-frame derivative mask for backprop.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : upstream handshake
//   in_data  [NBITS]    : pre-activation value, signed Q8.8
//   out_valid/out_ready : downstream handshake
//   out_data [NBITS]    : activated value, non-negative
//   out_last            : beat is index NEURONS-1 of its frame
//   mask     [NEURONS]  : derivative mask of last completed input frame
//   mask_valid          : one-cycle pulse when mask updates
// -----------------------------------------------------------------------------
module relu_fwd_stream
    import relu_pkg::*;
#(
    parameter int NBITS   = RELU_NBITS,
    parameter int NEURONS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NBITS-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NBITS-1:0]   out_data,
    output logic               out_last,
    output logic [NEURONS-1:0] mask,
    output logic               mask_valid
);

    localparam int IDXW = $clog2(NEURONS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NEURONS - 1);

    logic [IDXW-1:0]    idx_q, idx_d;
    logic [NEURONS-1:0] acc_q, acc_d;
    logic [NEURONS-1:0] mask_q, mask_d;
    logic               mask_valid_q, mask_valid_d;

    logic               accept;
    logic               is_last;
    logic [NBITS-1:0]   act;
    logic [NEURONS-1:0] acc_merged;

    assign accept  = in_valid & in_ready;
    assign is_last = (idx_q == LAST_IDX);

    generate
        if (NBITS == RELU_NBITS) begin : g_pkg_act
            assign act = relu_q88(in_data);
        end else begin : g_gen_act
            assign act = in_data[NBITS-1] ? '0 : in_data;
        end
    endgenerate

    // Zero counts as active (derivative 1.0 at 0), so the bit is just ~sign.
    always_comb begin
        acc_merged         = acc_q;
        acc_merged[idx_q]  = ~in_data[NBITS-1];
    end

    always_comb begin
        idx_d        = idx_q;
        acc_d        = acc_q;
        mask_d       = mask_q;
        mask_valid_d = 1'b0;

        if (accept) begin
            if (is_last) begin
                idx_d        = '0;
                acc_d        = '0;
                mask_d       = acc_merged;
                mask_valid_d = 1'b1;
            end else begin
                idx_d = idx_q + IDXW'(1);
                acc_d = acc_merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q        <= '0;
            acc_q        <= '0;
            mask_q       <= '0;
            mask_valid_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            mask_q       <= mask_d;
            mask_valid_q <= mask_valid_d;
        end
    end

    // out_last rides in the payload so it stays aligned with its beat.
    relu_skid_buf #(
        .WIDTH (NBITS + 1)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({is_last, act}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  ({out_last, out_data})
    );

    assign mask       = mask_q;
    assign mask_valid = mask_valid_q;

endmodule
